// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - AXI4 encodings and helpers shared by the AXI4-Lite to AXI4 bridge
package axi4_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Bits needed to hold an in-flight count from 0 up to max_count inclusive.
    function automatic int cnt_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/axi4_skid_buf.sv
// rtl/axi4_skid_buf.sv - two-entry registered skid buffer, or plain wires when REGISTERED = 0
module axi4_skid_buf #(
    parameter int WIDTH      = 32,
    parameter bit REGISTERED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    generate
        if (REGISTERED) begin : g_reg
            logic             head_valid;
            logic             skid_valid;
            logic [WIDTH-1:0] head_data;
            logic [WIDTH-1:0] skid_data;
            logic             push;

            assign push = in_valid && !skid_valid;

            // The skid entry only fills while the head is stalled, so it is always the younger beat.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    head_valid <= 1'b0;
                    skid_valid <= 1'b0;
                    head_data  <= '0;
                    skid_data  <= '0;
                end else if (!head_valid || out_ready) begin
                    if (skid_valid) begin
                        head_valid <= 1'b1;
                        head_data  <= skid_data;
                        skid_valid <= 1'b0;
                    end else begin
                        head_valid <= push;
                        if (push) begin
                            head_data <= in_data;
                        end
                    end
                end else if (push) begin
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                end
            end

            assign in_ready  = !skid_valid;
            assign out_valid = head_valid;
            assign out_data  = head_data;
            assign empty     = !head_valid && !skid_valid;
        end else begin : g_bypass
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_data  = in_data;
            assign empty     = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/axi4lite_axi4_bridge.sv
// rtl/axi4lite_axi4_bridge.sv - AXI4-Lite slave to AXI4 master bridge with outstanding limits and response checking
module axi4lite_axi4_bridge
    import axi4_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int ID_W            = 4,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4,
    parameter bit REG_REQ         = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                inport_awvalid_i,
    output logic                inport_awready_o,
    input  logic [ADDR_W-1:0]   inport_awaddr_i,
    input  logic                inport_wvalid_i,
    output logic                inport_wready_o,
    input  logic [DATA_W-1:0]   inport_wdata_i,
    input  logic [DATA_W/8-1:0] inport_wstrb_i,
    output logic                inport_bvalid_o,
    input  logic                inport_bready_i,
    output logic [1:0]          inport_bresp_o,
    input  logic                inport_arvalid_i,
    output logic                inport_arready_o,
    input  logic [ADDR_W-1:0]   inport_araddr_i,
    output logic                inport_rvalid_o,
    input  logic                inport_rready_i,
    output logic [DATA_W-1:0]   inport_rdata_o,
    output logic [1:0]          inport_rresp_o,

    output logic                outport_awvalid_o,
    input  logic                outport_awready_i,
    output logic [ADDR_W-1:0]   outport_awaddr_o,
    output logic [ID_W-1:0]     outport_awid_o,
    output logic [7:0]          outport_awlen_o,
    output logic [1:0]          outport_awburst_o,
    output logic                outport_wvalid_o,
    input  logic                outport_wready_i,
    output logic [DATA_W-1:0]   outport_wdata_o,
    output logic [DATA_W/8-1:0] outport_wstrb_o,
    output logic                outport_wlast_o,
    input  logic                outport_bvalid_i,
    output logic                outport_bready_o,
    input  logic [1:0]          outport_bresp_i,
    input  logic [ID_W-1:0]     outport_bid_i,
    output logic                outport_arvalid_o,
    input  logic                outport_arready_i,
    output logic [ADDR_W-1:0]   outport_araddr_o,
    output logic [ID_W-1:0]     outport_arid_o,
    output logic [7:0]          outport_arlen_o,
    output logic [1:0]          outport_arburst_o,
    input  logic                outport_rvalid_i,
    output logic                outport_rready_o,
    input  logic [DATA_W-1:0]   outport_rdata_i,
    input  logic [1:0]          outport_rresp_i,
    input  logic [ID_W-1:0]     outport_rid_i,
    input  logic                outport_rlast_i,

    output logic [3:0]          wr_outstanding_o,
    output logic [3:0]          rd_outstanding_o,
    output logic                idle_o
);

    localparam int                STRB_W  = DATA_W / 8;
    localparam int                CNT_W   = cnt_width(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [ID_W-1:0]   ID      = ID_W'(AXI_ID);

    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             wr_open;
    logic             rd_open;
    logic             aw_head_valid;
    logic             ar_head_valid;
    logic             aw_empty;
    logic             w_empty;
    logic             ar_empty;
    logic             wr_inc;
    logic             wr_dec;
    logic             rd_inc;
    logic             rd_dec;

    // The count only rises on a handshake of this same channel, so once the gate
    // opens for a waiting head it stays open until that head is accepted.
    assign wr_open = (wr_cnt != CNT_MAX);
    assign rd_open = (rd_cnt != CNT_MAX);

    axi4_skid_buf #(.WIDTH(ADDR_W), .REGISTERED(REG_REQ)) u_aw_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (inport_awvalid_i),
        .in_ready  (inport_awready_o),
        .in_data   (inport_awaddr_i),
        .out_valid (aw_head_valid),
        .out_ready (outport_awready_i && wr_open),
        .out_data  (outport_awaddr_o),
        .empty     (aw_empty)
    );

    axi4_skid_buf #(.WIDTH(DATA_W + STRB_W), .REGISTERED(REG_REQ)) u_w_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (inport_wvalid_i),
        .in_ready  (inport_wready_o),
        .in_data   ({inport_wstrb_i, inport_wdata_i}),
        .out_valid (outport_wvalid_o),
        .out_ready (outport_wready_i),
        .out_data  ({outport_wstrb_o, outport_wdata_o}),
        .empty     (w_empty)
    );

    axi4_skid_buf #(.WIDTH(ADDR_W), .REGISTERED(REG_REQ)) u_ar_buf (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (inport_arvalid_i),
        .in_ready  (inport_arready_o),
        .in_data   (inport_araddr_i),
        .out_valid (ar_head_valid),
        .out_ready (outport_arready_i && rd_open),
        .out_data  (outport_araddr_o),
        .empty     (ar_empty)
    );

    assign outport_awvalid_o = aw_head_valid && wr_open;
    assign outport_arvalid_o = ar_head_valid && rd_open;
    assign outport_awid_o    = ID;
    assign outport_arid_o    = ID;
    assign outport_awlen_o   = 8'd0;
    assign outport_arlen_o   = 8'd0;
    assign outport_awburst_o = AXI_BURST_INCR;
    assign outport_arburst_o = AXI_BURST_INCR;
    assign outport_wlast_o   = 1'b1;

    assign wr_inc = outport_awvalid_o && outport_awready_i;
    assign wr_dec = outport_bvalid_i && inport_bready_i && (wr_cnt != '0);
    assign rd_inc = outport_arvalid_o && outport_arready_i;
    assign rd_dec = outport_rvalid_i && inport_rready_i && outport_rlast_i && (rd_cnt != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (wr_inc && !wr_dec) begin
                wr_cnt <= wr_cnt + CNT_ONE;
            end else if (!wr_inc && wr_dec) begin
                wr_cnt <= wr_cnt - CNT_ONE;
            end
            if (rd_inc && !rd_dec) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end else if (!rd_inc && rd_dec) begin
                rd_cnt <= rd_cnt - CNT_ONE;
            end
        end
    end

    // Responses that do not belong to us, or that claim more than one beat, are reported as errors.
    assign inport_bvalid_o  = outport_bvalid_i;
    assign outport_bready_o = inport_bready_i;
    assign inport_bresp_o   = (outport_bid_i != ID) ? AXI_RESP_SLVERR : outport_bresp_i;
    assign inport_rvalid_o  = outport_rvalid_i;
    assign outport_rready_o = inport_rready_i;
    assign inport_rdata_o   = outport_rdata_i;
    assign inport_rresp_o   = ((outport_rid_i != ID) || !outport_rlast_i) ? AXI_RESP_SLVERR
                                                                          : outport_rresp_i;

    assign wr_outstanding_o = 4'(wr_cnt);
    assign rd_outstanding_o = 4'(rd_cnt);
    assign idle_o           = (wr_cnt == '0) && (rd_cnt == '0) && aw_empty && w_empty && ar_empty;

endmodule

// File: doc/axi4lite_axi4_bridge.md
Name: axi4lite_axi4_bridge

Overview:
Parametrised AXI4-Lite slave to AXI4 master bridge. Issues single-beat INCR bursts with a fixed ID, and optionally registers the request channels through skid buffers. Limits outstanding reads and writes independently and checks the ID and RLAST of every AXI4 response. Sits between SoC AXI4-Lite masters (CPU/debug) and AXI4 memory/interconnect ports.

Parameters:
ADDR_W, 32, address width, both sides
DATA_W, 32, data width; 32 or 64 only; WSTRB width = DATA_W/8
ID_W, 4, AXI4 ID width
AXI_ID, 0, constant ID driven on AWID/ARID and expected on BID/RID
MAX_OUTSTANDING, 4, maximum in-flight transactions per direction; range 1..15
REG_REQ, 1, 1 = skid buffer on AW, W and AR; 0 = combinational pass-through

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
inport_aw{valid,ready,addr}  in/out/in  1/1/ADDR_W  AXI4-Lite write address
inport_w{valid,ready,data,strb}  in/out/in/in  1/1/DATA_W/DATA_W/8  AXI4-Lite write data
inport_b{valid,ready,resp}  out/in/out  1/1/2  AXI4-Lite write response
inport_ar{valid,ready,addr}  in/out/in  1/1/ADDR_W  AXI4-Lite read address
inport_r{valid,ready,data,resp}  out/in/out/out  1/1/DATA_W/2  AXI4-Lite read data
outport_aw{valid,ready,addr,id,len,burst}  out/in/out/out/out/out  1/1/ADDR_W/ID_W/8/2  AXI4 write address
outport_w{valid,ready,data,strb,last}  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  AXI4 write data
outport_b{valid,ready,resp,id}  in/out/in/in  1/1/2/ID_W  AXI4 write response
outport_ar{valid,ready,addr,id,len,burst}  out/in/out/out/out/out  1/1/ADDR_W/ID_W/8/2  AXI4 read address
outport_r{valid,ready,data,resp,id,last}  in/out/in/in/in/in  1/1/DATA_W/2/ID_W/1  AXI4 read data
wr_outstanding_o  out  4  current write in-flight count
rd_outstanding_o  out  4  current read in-flight count
idle_o  out  1  both counts zero and all skid buffers empty

Behaviour:
- Constants: awlen = arlen = 0; awburst = arburst = 2'b01 (INCR); wlast = 1; awid = arid = AXI_ID.
- Reset (async assert, sync deassert by the caller): all valid outputs 0; counters 0; skid buffers empty; idle_o = 1; inport_*ready = 1 when REG_REQ = 1.
- Skid buffer (REG_REQ = 1): 2 entries. Output is registered: first beat appears on the outport 1 cycle after the inport handshake. Input ready = !second_entry_full, so full throughput is sustained. A stalled output holds its payload stable. REG_REQ = 0: wires only, zero latency.
- Write count wr_cnt: +1 on outport AW handshake, -1 on outport B handshake, unchanged when both occur in the same cycle.
  - outport_awvalid_o = aw_buf_valid && (wr_cnt != MAX_OUTSTANDING). The valid drop is permitted only before the handshake begins; once awvalid is asserted it is held until accepted, so the gate is evaluated on entry to the buffer head.
- Read count rd_cnt: the same rules on AR/R handshakes, with R counted only when rlast = 1.
- W channel is not count-gated; it passes through its skid buffer independently of AW, in either order.
- B/R channels are combinational pass-through; outport_bready_o = inport_bready_i, outport_rready_o = inport_rready_i.
- Response check: if bid != AXI_ID, inport_bresp_o = 2'b10 (SLVERR); otherwise bresp is passed unchanged. If rid != AXI_ID or rlast = 0, inport_rresp_o = 2'b10; otherwise rresp is passed unchanged. rdata is always passed.
- Underflow guard: a B or R handshake with count = 0 leaves the count at 0.
- Reset mid-transaction: buffers flush and counts clear immediately. In-flight responses arriving after reset are forwarded and do not decrement (underflow guard).
- Counter width 4 bits; outputs are zero-extended.

Decomposition:
- Package axi4_pkg: AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10; count-width function.
- Sub-module axi4_skid_buf, parameter WIDTH, instantiated 3x (AW: ADDR_W; W: DATA_W + DATA_W/8; AR: ADDR_W).
- Counters and the response check stay in the top level.

Test Plan:
- Single write: AW addr 0x1000 and W data 0xDEADBEEF strb 0xF in the same cycle, REG_REQ = 1 -> outport AW/W valid 1 cycle later with len 0, burst 1, id 0, wlast 1; B OKAY returned; wr_outstanding 1 -> 0.
- Outstanding limit: MAX_OUTSTANDING = 2, issue 3 ARs while holding rvalid low -> only 2 AR handshakes occur; 3rd arvalid stays low until the first R with rlast = 1; rd_outstanding peaks at 2.
- Back-to-back throughput: 8 ARs with outport_arready constantly 1 -> 8 handshakes in 8 consecutive cycles. Toggling arready 1010 keeps the payload stable and loses no request.
- Response check: R with rid = 3 (AXI_ID 0) and rresp OKAY -> inport_rresp 2'b10. R with rlast = 0 -> SLVERR. B with bid = 0 -> resp unchanged.
- Simultaneous events: AW handshake and B handshake in the same cycle at wr_cnt = 1 -> count stays 1. B with count 0 -> count stays 0.
- Reset mid-operation: assert rst_i with 2 buffered ARs -> all outport valids 0 asynchronously and counts 0. After release, idle_o = 1 and the next AR is issued normally.
